sobel_edge_stream: RTL
======================

Name: sobel_edge_stream

Overview:
- Parametrised streaming 3x3 Sobel edge detector for raster-order pixel streams with valid/ready flow control on input and output.
- Buffers two image lines internally and emits one gradient magnitude plus a thresholded edge bit per interior pixel.
- Supports a selectable magnitude mode and frame-start resynchronisation.
- Sits between the pixel source (camera/frame reader) and the edge-map writer.

Parameters:
- DATA_W, 8: pixel width in bits.
- IMG_W, 640: pixels per line (>=3).
- IMG_H, 480: lines per frame (>=3).
- MAG_MODE, 0: 0 = |gx|+|gy|; 1 = max(|gx|,|gy|).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pix_in  in  DATA_W  input pixel
- pix_valid  in  1  input pixel valid
- pix_sof  in  1  input pixel is frame pixel (0,0); qualified by pix_valid
- pix_ready  out  1  block accepts pixel this cycle
- threshold  in  DATA_W+3  edge threshold, sampled at frame start
- grad_out  out  DATA_W+3  gradient magnitude, unsigned
- edge_out  out  1  grad_out >= sampled threshold
- grad_valid  out  1  output valid
- grad_ready  in  1  downstream accepts output
- grad_sof  out  1  first output of frame
- grad_eol  out  1  last output of an output line
- frame_done  out  1  one-cycle pulse when the last input pixel of a frame is accepted
- frame_err  out  1  sticky; set on unexpected pix_sof, cleared only by rst

Behaviour:
- Reset is asynchronous, active-high. While rst is asserted:
  - grad_out, edge_out, grad_valid, grad_sof, grad_eol, frame_done and frame_err are 0.
  - col/row counters, pipeline valid bits and the sampled threshold are 0.
  - Line-buffer RAM contents are not reset.
- Flow control:
  - en = !grad_valid || grad_ready.
  - pix_ready = en.
  - A pixel is accepted when pix_valid && pix_ready.
  - All pipeline stages advance only when en; no output is ever dropped or duplicated.
- Stage 0 (on accept):
  - Write pix_in to line buffer at col; the old contents shift into the second buffer.
  - Shift the 3x3 window left by one, inserting column {line1[col], line0[col], pix_in}.
  - The window is valid iff row>=2 && col>=2, centred at (row-1, col-1).
- Counters:
  - col increments on each accept and wraps IMG_W-1 -> 0, with row incrementing.
  - The accept at (IMG_H-1, IMG_W-1) pulses frame_done and returns row/col to (0,0).
- Threshold is latched on acceptance of pixel (0,0).
- Stage 1:
  - gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20)
  - gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02)
  - Both are signed DATA_W+3 bits; range ±4*(2^DATA_W-1); no overflow.
- Stage 2:
  - MAG_MODE 0: grad_out = |gx| + |gy| (max 8*(2^DATA_W-1), fits DATA_W+3 unsigned).
  - MAG_MODE 1: grad_out = max(|gx|,|gy|), zero-extended.
  - edge_out is the unsigned compare against the sampled threshold.
- Latency with no stall: window formed at accept edge E; gx/gy registered at E+1; outputs registered at E+2, i.e. grad_valid is high after edge E+2.
- Output count: exactly (IMG_W-2)*(IMG_H-2) outputs per frame.
  - grad_sof is set on the output for centre (1,1).
  - grad_eol is set on centre column IMG_W-2.
- The output stream order is raster order of centres.
- Border pixels produce no output.
- pix_sof accepted while counters != (0,0):
  - Set frame_err.
  - Force the pixel to (0,0); the new frame proceeds normally.
  - The pipeline still drains in-flight outputs of the old frame.
- pix_sof accepted at (0,0): no error.
- pix_sof is ignored when not accepted.
- Simultaneous frame_done and next pixel: the next pixel is accepted as (0,0) in the following cycle; no bubble is required.
- rst mid-frame: everything restarts; the first frame after reset must be complete and correct, since stale line-buffer data is never used (window needs row>=2).

Test Plan:
1. Horizontal ramp:
   - Stimulus: DATA_W=8, IMG_W=8, IMG_H=6, MAG_MODE=0, pixel = 16*col, grad_ready=1.
   - Required response: 24 outputs, all grad_out=128; grad_sof on output 0; grad_eol on outputs 5,11,17,23; one frame_done pulse.
2. Vertical step:
   - Stimulus: rows 0-2 = 0, rows 3-5 = 255, threshold=512.
   - Required response: centre rows 1 and 4 output 0 with edge 0; centre rows 2 and 3 output 1020 with edge 1.
3. Backpressure:
   - Stimulus: test 1 with grad_ready random 50% and pix_valid random 70%.
   - Required response: identical 24-value sequence; pix_ready low exactly when grad_valid && !grad_ready; grad_out/flags stable while stalled.
4. Flat image in MAG_MODE=1:
   - Stimulus: MAG_MODE=1, flat image of 100, threshold=1; then vertical step from test 2.
   - Required response: flat image gives all grad_out=0 and edge_out=0; vertical step gives max mode 1020.
5. Unexpected pix_sof:
   - Stimulus: pix_sof asserted on the 20th pixel of a frame, then a full ramp frame.
   - Required response: frame_err=1 and stays set; the following frame yields 24 correct outputs of 128.
6. Reset mid-frame:
   - Stimulus: assert rst between clock edges mid-frame.
   - Required response: all outputs 0 immediately, pix_ready=1 after release; the next full frame is correct.

Source files
------------

// File: rtl/sobel_edge_stream_if.sv
// Pixel-in / gradient-out stream bundle for the Sobel edge detector.
// master = pixel source plus edge-map sink side, slave = the detector.
interface sobel_edge_stream_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic [DATA_W-1:0] pix_in;
   logic              pix_valid;
   logic              pix_sof;
   logic              pix_ready;
   logic [DATA_W+2:0] threshold;
   logic [DATA_W+2:0] grad_out;
   logic              edge_out;
   logic              grad_valid;
   logic              grad_ready;
   logic              grad_sof;
   logic              grad_eol;
   logic              frame_done;
   logic              frame_err;

   modport master (
      output pix_in, pix_valid, pix_sof, threshold, grad_ready,
      input  pix_ready, grad_out, edge_out, grad_valid, grad_sof, grad_eol,
             frame_done, frame_err
   );

   modport slave (
      input  pix_in, pix_valid, pix_sof, threshold, grad_ready,
      output pix_ready, grad_out, edge_out, grad_valid, grad_sof, grad_eol,
             frame_done, frame_err
   );
endinterface

// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers, window stage,
// gradient stage, magnitude/threshold stage, all stalled by one enable.
module sobel_edge_stream #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned IMG_W    = 640,
   parameter int unsigned IMG_H    = 480,
   parameter int unsigned MAG_MODE = 0
) (
   input  logic               clk,
   input  logic               rst,
   sobel_edge_stream_if.slave bus
);
   localparam int unsigned GW = DATA_W + 3;
   localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic              en, acc, sof_acc, at_origin, last_pix;
   logic [CW-1:0]     col, col_e;
   logic [RW-1:0]     row, row_e;
   logic [DATA_W-1:0] line0 [IMG_W];
   logic [DATA_W-1:0] line1 [IMG_W];
   logic [DATA_W-1:0] win [3][3];
   logic              v0, sof0, eol0, v1, sof1, eol1;
   logic [GW-1:0]     gx, gy, gx_c, gy_c, ax, ay, mag;
   logic [GW-1:0]     thr, thr1;

   assign en            = !bus.grad_valid || bus.grad_ready;
   assign bus.pix_ready = en;
   assign acc           = bus.pix_valid && en;
   assign sof_acc       = acc && bus.pix_sof;
   assign at_origin     = (col == '0) && (row == '0);
   // An accepted pix_sof always forces the pixel to the frame origin
   assign col_e         = sof_acc ? '0 : col;
   assign row_e         = sof_acc ? '0 : row;
   assign last_pix      = (row_e == RW'(IMG_H - 1)) && (col_e == CW'(IMG_W - 1));

   // Line buffers and window: data only, never reset
   always_ff @(posedge clk) begin
      if (acc) begin
         line0[col_e] <= bus.pix_in;
         line1[col_e] <= line0[col_e];
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= line1[col_e];
         win[1][2] <= line0[col_e];
         win[2][2] <= bus.pix_in;
      end
   end

   // Sobel kernels in GW-bit two's complement; the range never overflows
   assign gx_c = (GW'(win[0][2]) + (GW'(win[1][2]) << 1) + GW'(win[2][2]))
               - (GW'(win[0][0]) + (GW'(win[1][0]) << 1) + GW'(win[2][0]));
   assign gy_c = (GW'(win[2][0]) + (GW'(win[2][1]) << 1) + GW'(win[2][2]))
               - (GW'(win[0][0]) + (GW'(win[0][1]) << 1) + GW'(win[0][2]));

   always_comb begin
      ax  = gx[GW-1] ? GW'(-gx) : gx;
      ay  = gy[GW-1] ? GW'(-gy) : gy;
      mag = ax + ay;
      if (MAG_MODE != 0) mag = (ax > ay) ? ax : ay;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col            <= '0;
         row            <= '0;
         thr            <= '0;
         thr1           <= '0;
         v0             <= 1'b0;
         sof0           <= 1'b0;
         eol0           <= 1'b0;
         v1             <= 1'b0;
         sof1           <= 1'b0;
         eol1           <= 1'b0;
         gx             <= '0;
         gy             <= '0;
         bus.grad_out   <= '0;
         bus.edge_out   <= 1'b0;
         bus.grad_valid <= 1'b0;
         bus.grad_sof   <= 1'b0;
         bus.grad_eol   <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.frame_err  <= 1'b0;
      end else begin
         bus.frame_done <= acc && last_pix;
         if (sof_acc && !at_origin) bus.frame_err <= 1'b1;
         if (acc) begin
            if ((col_e == '0) && (row_e == '0)) thr <= bus.threshold;
            if (col_e == CW'(IMG_W - 1)) begin
               col <= '0;
               row <= last_pix ? '0 : row_e + RW'(1);
            end else begin
               col <= col_e + CW'(1);
               row <= row_e;
            end
         end
         if (en) begin
            v0             <= acc && (row_e >= RW'(2)) && (col_e >= CW'(2));
            sof0           <= (row_e == RW'(2)) && (col_e == CW'(2));
            eol0           <= col_e == CW'(IMG_W - 1);
            v1             <= v0;
            sof1           <= sof0;
            eol1           <= eol0;
            gx             <= gx_c;
            gy             <= gy_c;
            // Threshold travels with the data so a new frame cannot retag old outputs
            thr1           <= thr;
            bus.grad_valid <= v1;
            bus.grad_out   <= mag;
            bus.edge_out   <= mag >= thr1;
            bus.grad_sof   <= v1 && sof1;
            bus.grad_eol   <= v1 && eol1;
         end
      end
   end
endmodule
